// File: rtl/wb_ctrl.sv
// Regfile writeback controller: ALU/load merge, load-return FIFO, load scoreboard.
// Optional WB_BYPASS_EN adds writeback-to-decode forwarding and hazard masking.
module wb_ctrl #(
    parameter int LD_DEPTH = 4,
    parameter int XLEN     = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            iss_valid_i,
    input  logic            iss_is_load_i,
    input  logic [4:0]      iss_rd_i,
    output logic            iss_ready_o,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    output logic            hazard_o,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            lsu_valid_i,
    input  logic [4:0]      lsu_rd_i,
    input  logic [XLEN-1:0] lsu_data_i,
    output logic            lsu_ready_o,
`ifdef WB_BYPASS_EN
    output logic            fwd_rs1_hit_o,
    output logic            fwd_rs2_hit_o,
    output logic [XLEN-1:0] fwd_rs1_data_o,
    output logic [XLEN-1:0] fwd_rs2_data_o,
`endif
    output logic            rd_wren_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [31:0]     busy_o
);
    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      rd_mem_q  [LD_DEPTH];
    logic [XLEN-1:0] dat_mem_q [LD_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     busy_q, busy_d;
    logic            wren_q, wren_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;

    logic            full, empty, push, pop;
    logic            sel_v;
    logic [4:0]      sel_rd, clr_rd;
    logic [XLEN-1:0] sel_data;
    logic            busy_set, busy_clr;
    logic            hz1, hz2;

    assign full        = (count_q == CW'(LD_DEPTH));
    assign empty       = (count_q == '0);
    assign lsu_ready_o = !full;
    assign push        = lsu_valid_i && !full;
    assign pop         = !alu_valid_i && !empty;
    assign clr_rd      = rd_mem_q[rd_ptr_q];
    assign busy_clr    = pop;
    assign iss_ready_o = !busy_q[iss_rd_i] || (iss_rd_i == 5'd0);
    assign busy_set    = iss_valid_i && iss_ready_o && iss_is_load_i
                         && (iss_rd_i != 5'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
    end

    // ALU has strict priority; loads wait in the FIFO until a free slot
    always_comb begin
        sel_v    = 1'b0;
        sel_rd   = 5'd0;
        sel_data = '0;
        if (alu_valid_i) begin
            sel_v    = 1'b1;
            sel_rd   = alu_rd_i;
            sel_data = alu_data_i;
        end else if (!empty) begin
            sel_v    = 1'b1;
            sel_rd   = clr_rd;
            sel_data = dat_mem_q[rd_ptr_q];
        end
        wren_d = sel_v && (sel_rd != 5'd0);
        addr_d = wren_d ? sel_rd : addr_q;
        data_d = wren_d ? sel_data : data_q;
    end

    always_comb begin
        busy_d = busy_q;
        if (busy_clr) busy_d[clr_rd] = 1'b0;
        if (busy_set) busy_d[iss_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    // A busy bit clearing this cycle is covered by the forward path next cycle
    assign hz1 = (rs1_i != 5'd0) && busy_q[rs1_i]
                 && !(busy_clr && clr_rd == rs1_i);
    assign hz2 = (rs2_i != 5'd0) && busy_q[rs2_i]
                 && !(busy_clr && clr_rd == rs2_i);
    assign fwd_rs1_hit_o  = wren_q && (addr_q == rs1_i) && (rs1_i != 5'd0);
    assign fwd_rs2_hit_o  = wren_q && (addr_q == rs2_i) && (rs2_i != 5'd0);
    assign fwd_rs1_data_o = data_q;
    assign fwd_rs2_data_o = data_q;
`else
    assign hz1 = (rs1_i != 5'd0) && busy_q[rs1_i];
    assign hz2 = (rs2_i != 5'd0) && busy_q[rs2_i];
`endif
    assign hazard_o = hz1 || hz2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            wren_q   <= 1'b0;
            addr_q   <= 5'd0;
            data_q   <= '0;
            for (int i = 0; i < LD_DEPTH; i++) begin
                rd_mem_q[i]  <= 5'd0;
                dat_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            if (push) begin
                rd_mem_q[wr_ptr_q]  <= lsu_rd_i;
                dat_mem_q[wr_ptr_q] <= lsu_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni)
            assert (!(busy_set && busy_clr && clr_rd == iss_rd_i));
    end

    assign rd_wren_o = wren_q;
    assign rd_addr_o = addr_q;
    assign rd_data_o = data_q;
    assign busy_o    = busy_q;
endmodule
